// File: rtl/vcsa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vcsa_pkg
// Brief    : Block partition helpers for the variable-block carry-select adder
//            (sizes 4,4,5,6,6,7,8,8,9,...; last block truncated to fit n).
// Revision : 1.0
// ============================================================================
package vcsa_pkg;

  localparam int BLK0_W = 4;

  // Untruncated width of block idx: grows by one on two of every three blocks.
  function automatic int nominal_width(input int idx);
    return BLK0_W + idx - ((idx + 2) / 3);
  endfunction

  function automatic int blk_start(input int idx, input int n);
    int s;
    s = 0;
    for (int i = 0; i < idx; i++) s = s + nominal_width(i);
    return (s > n) ? n : s;
  endfunction

  function automatic int blk_width(input int idx, input int n);
    int s;
    int w;
    s = blk_start(idx, n);
    w = nominal_width(idx);
    return (s + w > n) ? (n - s) : w;
  endfunction

  function automatic int num_blocks(input int n);
    int k;
    k = 0;
    while (blk_start(k, n) < n) k = k + 1;
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vcsa_rca.sv
`default_nettype none
// ============================================================================
// Module   : vcsa_rca
// Brief    : W-bit ripple-carry adder used as the building block of the VCSA.
// Revision : 1.0
// ============================================================================
module vcsa_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic c;

  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule
`default_nettype wire

// File: rtl/vcsa_adder.sv
`default_nettype none
// ============================================================================
// Module   : vcsa_adder
// Brief    : Registered variable-block carry-select adder, {Cout,S} = A+B+Cin.
//            Optional macro VCSA_OVF_EN adds a registered signed-overflow flag Ovf.
// Revision : 1.0
// ============================================================================
module vcsa_adder
  import vcsa_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         Cin,
  output logic [n-1:0] S,
  output logic         Cout
`ifdef VCSA_OVF_EN
  ,
  output logic         Ovf
`endif
);

  localparam int NB = num_blocks(n);

  logic [n-1:0] sum;

  // Each block owns its carry-out; the next block reaches back for it so the
  // carry chain is not one self-referencing vector.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int ST = blk_start(k, n);
    localparam int W  = blk_width(k, n);
    logic cout;

    if (k == 0) begin : g_ripple
      vcsa_rca #(.W(W)) u_rca (
        .a  (A[ST +: W]),
        .b  (B[ST +: W]),
        .ci (Cin),
        .s  (sum[ST +: W]),
        .co (cout)
      );
    end else begin : g_csel
      logic [W-1:0] s0;
      logic [W-1:0] s1;
      logic         c0;
      logic         c1;
      logic         cin_blk;

      assign cin_blk = g_blk[k-1].cout;

      vcsa_rca #(.W(W)) u_rca0 (
        .a  (A[ST +: W]),
        .b  (B[ST +: W]),
        .ci (1'b0),
        .s  (s0),
        .co (c0)
      );

      vcsa_rca #(.W(W)) u_rca1 (
        .a  (A[ST +: W]),
        .b  (B[ST +: W]),
        .ci (1'b1),
        .s  (s1),
        .co (c1)
      );

      assign sum[ST +: W] = cin_blk ? s1 : s0;
      assign cout         = cin_blk ? c1 : c0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= sum;
      Cout <= g_blk[NB-1].cout;
    end
  end

`ifdef VCSA_OVF_EN
  // Carry-in XOR carry-out of the MSB is equivalent to: like-signed operands
  // producing a sum of the opposite sign.
  logic ovf;
  assign ovf = (A[n-1] ~^ B[n-1]) & (sum[n-1] ^ A[n-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) Ovf <= 1'b0;
    else     Ovf <= ovf;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vcsa_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vcsa_adder
// Brief    : Directed self-checking bench for vcsa_adder (n=32).
// Revision : 1.0
// ============================================================================
module tb_vcsa_adder;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N-1:0] S;
  logic         Cout;
`ifdef VCSA_OVF_EN
  logic         Ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic         pend = 1'b0;
  logic [N-1:0] exp_s;
  logic         exp_c;
  logic         exp_o;
  string        exp_tag;

  vcsa_adder #(.n(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout)
`ifdef VCSA_OVF_EN
    ,
    .Ovf  (Ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk_s(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: S observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_pending();
    chk_s({exp_tag, ".S"}, S, exp_s);
    chk_b({exp_tag, ".Cout"}, Cout, exp_c);
`ifdef VCSA_OVF_EN
    chk_b({exp_tag, ".Ovf"}, Ovf, exp_o);
`endif
  endtask

  // Checks the result of the previous vector, then drives a new one: one
  // vector per cycle, result due exactly one edge later.
  task automatic step(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic cin);
    logic [N:0] full;
    @(negedge clk);
    if (pend) check_pending();
    A   = a;
    B   = b;
    Cin = cin;
    full    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    exp_s   = full[N-1:0];
    exp_c   = full[N];
    exp_o   = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
    exp_tag = tag;
    pend    = 1'b1;
  endtask

  task automatic flush();
    @(negedge clk);
    if (pend) check_pending();
    pend = 1'b0;
  endtask

  initial begin
    int bp [6];
    bp = '{0, 4, 8, 13, 19, 25};

    rst = 1'b1;
    A   = '0;
    B   = '0;
    Cin = 1'b0;
    repeat (2) @(negedge clk);
    chk_s("reset.S", S, 32'h0);
    chk_b("reset.Cout", Cout, 1'b0);
`ifdef VCSA_OVF_EN
    chk_b("reset.Ovf", Ovf, 1'b0);
`endif

    rst = 1'b0;
    A   = 32'hFFFF_FFFF;
    B   = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_s("ones.S", S, 32'hFFFF_FFFE);
    chk_b("ones.Cout", Cout, 1'b1);

    // Asynchronous assertion between edges must clear outputs at once.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_s("async_rst.S", S, 32'h0);
    chk_b("async_rst.Cout", Cout, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_s("rst_hold.S", S, 32'h0);
    chk_b("rst_hold.Cout", Cout, 1'b0);

    rst = 1'b0;
    @(negedge clk);
    chk_s("rst_release.S", S, 32'hFFFF_FFFE);
    chk_b("rst_release.Cout", Cout, 1'b1);

    step("wrap", 32'hFFFF_FFFF, 32'h0, 1'b1);
    step("blk01", 32'h0000_000F, 32'h1, 1'b0);
    step("max_lo", 32'd1023, 32'd1023, 1'b1);
    step("ones_cin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    for (int i = 0; i < 6; i++) begin
      step("bnd_b", (32'h1 << bp[i]) - 32'h1, 32'h1, 1'b0);
      step("bnd_cin", (32'h1 << bp[i]) - 32'h1, 32'h0, 1'b1);
    end

    for (int a = 0; a < 1024; a++) begin
      step("low_field", 32'(a), 32'((a * 37 + 511) & 1023), a[0]);
    end

`ifdef VCSA_OVF_EN
    step("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0);
    step("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0);
    step("no_ovf", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
`endif

    for (int i = 0; i < 10000; i++) begin
      step("random", $urandom, $urandom, 1'($urandom_range(1)));
    end
    flush();

    // Hand-computed spot checks independent of the arithmetic model.
    step("hand1", 32'h0000_000F, 32'h1, 1'b0);
    @(negedge clk);
    chk_s("hand1.S", S, 32'h0000_0010);
    chk_b("hand1.Cout", Cout, 1'b0);
    pend = 1'b0;
    step("hand2", 32'd1023, 32'd1023, 1'b1);
    @(negedge clk);
    chk_s("hand2.S", S, 32'd2047);
    chk_b("hand2.Cout", Cout, 1'b0);
    pend = 1'b0;
`ifdef VCSA_OVF_EN
    step("hand3", 32'h8000_0000, 32'h8000_0000, 1'b0);
    @(negedge clk);
    chk_s("hand3.S", S, 32'h0);
    chk_b("hand3.Cout", Cout, 1'b1);
    chk_b("hand3.Ovf", Ovf, 1'b1);
    pend = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
